// File: rtl/mig_if_burst_pkg.sv
// Shared constants, FSM state type and helpers for the MIG user-interface burst bridge.
package mig_if_pkg;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [1:0] {
    IDLE,
    RD_ISSUE,
    WR_ISSUE
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mig_if_burst_if.sv
// Bundle of MIG app, request-queue, write-data-queue and read-data-queue signals.
interface mig_if_burst_if #(
  parameter int DATA_W = 128,
  parameter int MASK_W = DATA_W / 8,
  parameter int ADDR_W = 28,
  parameter int LEN_W  = 3
);

  logic [ADDR_W-1:0]        app_addr;
  logic [2:0]               app_cmd;
  logic                     app_en;
  logic                     app_rdy;
  logic [DATA_W-1:0]        app_wdf_data;
  logic [MASK_W-1:0]        app_wdf_mask;
  logic                     app_wdf_wren;
  logic                     app_wdf_end;
  logic                     app_wdf_rdy;
  logic [DATA_W-1:0]        app_rd_data;
  logic                     app_rd_data_valid;
  logic                     req_rnext;
  logic                     req_rqempty;
  logic [31:0]              req_qraddr;
  logic                     req_rd_bwt;
  logic [LEN_W-1:0]         req_len;
  logic                     wdq_rnext;
  logic                     wdq_rqempty;
  logic [MASK_W+DATA_W-1:0] wdq_mask_rdata;
  logic                     rdq_wen;
  logic [DATA_W-1:0]        rdq_wdata;
  logic                     rdq_last;
  logic                     rdq_pop;
  logic                     rd_err;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output req_rnext, wdq_rnext, rdq_wen, rdq_wdata, rdq_last, rd_err,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    input  req_rqempty, req_qraddr, req_rd_bwt, req_len,
    input  wdq_rqempty, wdq_mask_rdata, rdq_pop
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  req_rnext, wdq_rnext, rdq_wen, rdq_wdata, rdq_last, rd_err,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    output req_rqempty, req_qraddr, req_rd_bwt, req_len,
    output wdq_rqempty, wdq_mask_rdata, rdq_pop
  );

endinterface

// File: rtl/mig_if_burst_len_fifo.sv
// Small synchronous FIFO holding the length of each outstanding read request;
// push and pop in the same cycle are both honoured.
module mig_len_fifo
  import mig_if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         mclk,
  input  logic         mrst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge mclk) begin
    if (mrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is pure data: no reset, validity is tracked by count_q.
  always_ff @(posedge mclk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mig_if_burst.sv
// MIG user-interface bridge: expands queued requests into single-beat MIG commands,
// streams write data, and forwards read returns with last-beat marking and credit control.
module mig_if_burst
  import mig_if_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int MASK_W     = DATA_W / 8,
  parameter int ADDR_W     = 28,
  parameter int LEN_W      = 3,
  parameter int RDQ_DEPTH  = 16,
  parameter int MAX_RD_REQ = 4
) (
  input logic            mclk,
  input logic            mrst,
  mig_if_burst_if.master bus
);

  localparam int COL_SHIFT = clog2(MASK_W);
  localparam int CNT_W     = LEN_W + 1;
  localparam int CR_W      = clog2(RDQ_DEPTH + 1);
  localparam logic [CR_W-1:0] CREDIT_MAX = CR_W'(RDQ_DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cmd_cnt_q, cmd_cnt_d;
  logic [CNT_W-1:0] dat_cnt_q, dat_cnt_d;
  logic [LEN_W-1:0] rbeat_cnt_q, rbeat_cnt_d;
  logic [CR_W-1:0]  credit_q, credit_d;
  logic [CR_W:0]    credit_sum;
  logic             rd_err_q, rd_err_d;

  logic [CNT_W-1:0]  len_ext;
  logic              cmd_last, dat_last, dat_pending;
  logic [ADDR_W-2:0] col_addr;
  logic              app_en_c, wren_c, rnext_c;
  logic [2:0]        app_cmd_c;
  logic [ADDR_W-1:0] app_addr_c;
  logic              cmd_acc, wdf_acc, rd_acc;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [LEN_W-1:0]  fifo_head;
  logic              rdq_last_c;

  assign len_ext     = {1'b0, bus.req_len};
  assign cmd_last    = (cmd_cnt_q == len_ext);
  assign dat_last    = (dat_cnt_q == len_ext);
  assign dat_pending = (dat_cnt_q <= len_ext);

  // Column address wraps inside the low ADDR_W-1 bits; the MSB is always 0.
  assign col_addr = (ADDR_W-1)'((bus.req_qraddr >> COL_SHIFT) << 3)
                  + (ADDR_W-1)'({cmd_cnt_q, 3'b000});

  assign cmd_acc = app_en_c & bus.app_rdy;
  assign wdf_acc = wren_c & bus.app_wdf_rdy;
  assign rd_acc  = cmd_acc & (state_q == RD_ISSUE);

  // FSM output decode
  always_comb begin
    app_en_c   = 1'b0;
    app_cmd_c  = CMD_WR;
    app_addr_c = '0;
    wren_c     = 1'b0;
    rnext_c    = 1'b0;
    case (state_q)
      RD_ISSUE: begin
        app_en_c   = (credit_q != '0);
        app_cmd_c  = CMD_RD;
        app_addr_c = {1'b0, col_addr};
        rnext_c    = app_en_c & bus.app_rdy & cmd_last;
      end
      WR_ISSUE: begin
        app_en_c   = (cmd_cnt_q <= len_ext);
        app_cmd_c  = CMD_WR;
        app_addr_c = {1'b0, col_addr};
        wren_c     = dat_pending & ~bus.wdq_rqempty;
        // Pop the request once both sides are finished, counting this cycle's accepts.
        rnext_c    = (~app_en_c | (bus.app_rdy & cmd_last))
                   & (~dat_pending | (wren_c & bus.app_wdf_rdy & dat_last));
      end
      default: ;
    endcase
  end

  // FSM next state and burst counters
  always_comb begin
    state_d   = state_q;
    cmd_cnt_d = cmd_cnt_q;
    dat_cnt_d = dat_cnt_q;
    fifo_push = 1'b0;
    case (state_q)
      IDLE: begin
        if (~bus.req_rqempty) begin
          if (bus.req_rd_bwt) begin
            if (~fifo_full) begin
              state_d   = RD_ISSUE;
              fifo_push = 1'b1;
              cmd_cnt_d = '0;
            end
          end else begin
            state_d   = WR_ISSUE;
            cmd_cnt_d = '0;
            dat_cnt_d = '0;
          end
        end
      end
      RD_ISSUE: begin
        if (cmd_acc) cmd_cnt_d = cmd_cnt_q + 1'b1;
        if (rnext_c) state_d = IDLE;
      end
      WR_ISSUE: begin
        if (cmd_acc) cmd_cnt_d = cmd_cnt_q + 1'b1;
        if (wdf_acc) dat_cnt_d = dat_cnt_q + 1'b1;
        if (rnext_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // rdq credit: saturates at RDQ_DEPTH, never underflows since accepts need credit.
  always_comb begin
    credit_sum = {1'b0, credit_q} + (CR_W+1)'(bus.rdq_pop) - (CR_W+1)'(rd_acc);
    credit_d   = (credit_sum > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : credit_sum[CR_W-1:0];
  end

  always_comb begin
    rdq_last_c  = bus.app_rd_data_valid & ~fifo_empty & (rbeat_cnt_q == fifo_head);
    fifo_pop    = rdq_last_c;
    rbeat_cnt_d = rbeat_cnt_q;
    if (bus.app_rd_data_valid & ~fifo_empty)
      rbeat_cnt_d = rdq_last_c ? '0 : rbeat_cnt_q + 1'b1;
    rd_err_d    = rd_err_q | (bus.app_rd_data_valid & fifo_empty);
  end

  always_ff @(posedge mclk) begin
    if (mrst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge mclk) begin
    if (mrst) begin
      cmd_cnt_q   <= '0;
      dat_cnt_q   <= '0;
      rbeat_cnt_q <= '0;
      credit_q    <= CREDIT_MAX;
      rd_err_q    <= 1'b0;
    end else begin
      cmd_cnt_q   <= cmd_cnt_d;
      dat_cnt_q   <= dat_cnt_d;
      rbeat_cnt_q <= rbeat_cnt_d;
      credit_q    <= credit_d;
      rd_err_q    <= rd_err_d;
    end
  end

  mig_len_fifo #(
    .DEPTH (MAX_RD_REQ),
    .W     (LEN_W)
  ) u_len_fifo (
    .mclk      (mclk),
    .mrst      (mrst),
    .push      (fifo_push),
    .push_data (bus.req_len),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.app_en       = app_en_c;
  assign bus.app_cmd      = app_cmd_c;
  assign bus.app_addr     = app_addr_c;
  assign bus.app_wdf_data = bus.wdq_mask_rdata[DATA_W-1:0];
  assign bus.app_wdf_mask = bus.wdq_mask_rdata[MASK_W+DATA_W-1:DATA_W];
  assign bus.app_wdf_wren = wren_c;
  assign bus.app_wdf_end  = wren_c;
  assign bus.wdq_rnext    = wdf_acc;
  assign bus.req_rnext    = rnext_c;
  assign bus.rdq_wen      = bus.app_rd_data_valid;
  assign bus.rdq_wdata    = bus.app_rd_data;
  assign bus.rdq_last     = rdq_last_c;
  assign bus.rd_err       = rd_err_q;

endmodule

// File: tb/tb_mig_if_burst.sv
// Directed bench for mig_if_burst: reads, writes with backpressure, credit limit,
// interleaved read returns, stray returns, mid-burst reset and length-fifo full.
module tb_mig_if_burst;

  localparam int DATA_W     = 128;
  localparam int MASK_W     = DATA_W / 8;
  localparam int ADDR_W     = 28;
  localparam int LEN_W      = 3;
  localparam int RDQ_DEPTH  = 4;
  localparam int MAX_RD_REQ = 2;

  logic mclk;
  logic mrst;
  int   ntests;
  int   nfail;

  mig_if_burst_if #(.DATA_W(DATA_W), .MASK_W(MASK_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  mig_if_burst #(
    .DATA_W(DATA_W), .MASK_W(MASK_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
    .RDQ_DEPTH(RDQ_DEPTH), .MAX_RD_REQ(MAX_RD_REQ)
  ) dut (
    .mclk (mclk),
    .mrst (mrst),
    .bus  (bus)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic present, input logic rd, input logic [31:0] a,
                         input logic [LEN_W-1:0] l);
    bus.req_rqempty = ~present;
    bus.req_rd_bwt  = rd;
    bus.req_qraddr  = a;
    bus.req_len     = l;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ncmd, ndat, nrn, rn_cyc, nacc, kacc, beat;
    logic vld;
    ntests = 0;
    nfail  = 0;
    bus.app_rdy = 1'b0;
    bus.app_wdf_rdy = 1'b0;
    bus.app_rd_data = '0;
    bus.app_rd_data_valid = 1'b0;
    bus.wdq_rqempty = 1'b1;
    bus.wdq_mask_rdata = '0;
    bus.rdq_pop = 1'b0;
    set_req(1'b0, 1'b0, 32'h0, '0);

    // Reset state
    mrst = 1'b1;
    step();
    step();
    chk("rst_app_en", 128'(bus.app_en), 128'h0);
    chk("rst_wren", 128'(bus.app_wdf_wren), 128'h0);
    chk("rst_rnext", 128'(bus.req_rnext), 128'h0);
    chk("rst_wdq_rnext", 128'(bus.wdq_rnext), 128'h0);
    chk("rst_rd_err", 128'(bus.rd_err), 128'h0);
    chk("rst_rdq_wen", 128'(bus.rdq_wen), 128'h0);

    // Single-beat read at 0x120
    mrst = 1'b0;
    set_req(1'b1, 1'b1, 32'h0000_0120, 3'd0);
    bus.app_rdy = 1'b1;
    #1;
    chk("t1_idle_en", 128'(bus.app_en), 128'h0);
    step();
    chk("t1_en", 128'(bus.app_en), 128'h1);
    chk("t1_cmd", 128'(bus.app_cmd), 128'h1);
    chk("t1_addr", 128'(bus.app_addr), 128'h090);
    chk("t1_rnext", 128'(bus.req_rnext), 128'h1);
    step();
    bus.req_rqempty = 1'b1;
    #1;
    chk("t1_back_idle_en", 128'(bus.app_en), 128'h0);
    chk("t1_rnext_once", 128'(bus.req_rnext), 128'h0);
    bus.app_rd_data_valid = 1'b1;
    bus.app_rd_data = 128'hCAFE_0001;
    #1;
    chk("t1_rdq_wen", 128'(bus.rdq_wen), 128'h1);
    chk("t1_rdq_last", 128'(bus.rdq_last), 128'h1);
    chk("t1_rdq_wdata", bus.rdq_wdata, 128'hCAFE_0001);
    step();
    bus.app_rd_data_valid = 1'b0;
    #1;
    chk("t1_rd_err", 128'(bus.rd_err), 128'h0);
    chk("t1_rdq_wen_off", 128'(bus.rdq_wen), 128'h0);

    // Write len 3 at 0x40; app_rdy on odd cycles, wdf_rdy low for cycles 0..4
    set_req(1'b1, 1'b0, 32'h40, 3'd3);
    ncmd = 0; ndat = 0; nrn = 0; rn_cyc = -1;
    for (int c = 0; c < 20; c++) begin
      bus.app_rdy = c[0];
      bus.app_wdf_rdy = (c >= 5);
      bus.wdq_rqempty = (ndat >= 4);
      bus.wdq_mask_rdata = {16'(ndat + 1), 128'(32'hD000 + ndat)};
      bus.req_rqempty = (nrn != 0);
      #1;
      if (bus.app_en && bus.app_rdy) begin
        chk("t2_addr", 128'(bus.app_addr), 128'(32'h20 + 8 * ncmd));
        chk("t2_cmd", 128'(bus.app_cmd), 128'h0);
        ncmd++;
      end
      if (bus.wdq_rnext) begin
        chk("t2_data", bus.app_wdf_data, 128'(32'hD000 + ndat));
        chk("t2_mask", 128'(bus.app_wdf_mask), 128'(ndat + 1));
        chk("t2_end", 128'(bus.app_wdf_end), 128'h1);
        ndat++;
      end
      if (bus.req_rnext) begin
        nrn++;
        rn_cyc = c;
      end
      step();
    end
    chk("t2_ncmd", 128'(ncmd), 128'd4);
    chk("t2_ndat", 128'(ndat), 128'd4);
    chk("t2_nrnext", 128'(nrn), 128'd1);
    chk("t2_rnext_cycle", 128'(rn_cyc), 128'd8);
    chk("t2_idle_en", 128'(bus.app_en), 128'h0);

    // Credit limit: read len 7 with 4 credits, then two rdq_pop pulses
    mrst = 1'b1;
    bus.wdq_rqempty = 1'b1;
    step();
    mrst = 1'b0;
    set_req(1'b1, 1'b1, 32'h0, 3'd7);
    bus.app_rdy = 1'b1;
    nacc = 0; nrn = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.app_en && bus.app_rdy) begin
        chk("t3_addr", 128'(bus.app_addr), 128'(8 * nacc));
        nacc++;
      end
      if (bus.req_rnext) nrn++;
      step();
    end
    chk("t3_acc_4", 128'(nacc), 128'd4);
    chk("t3_en_stalled", 128'(bus.app_en), 128'h0);
    for (int c = 0; c < 6; c++) begin
      bus.rdq_pop = (c < 2);
      #1;
      if (bus.app_en && bus.app_rdy) nacc++;
      if (bus.req_rnext) nrn++;
      step();
    end
    bus.rdq_pop = 1'b0;
    #1;
    chk("t3_acc_6", 128'(nacc), 128'd6);
    chk("t3_en_stalled2", 128'(bus.app_en), 128'h0);
    chk("t3_no_rnext", 128'(nrn), 128'd0);

    // Back-to-back reads len 1 then len 2; consumer keeps popping
    mrst = 1'b1;
    step();
    mrst = 1'b0;
    bus.rdq_pop = 1'b1;
    nrn = 0; nacc = 0; kacc = 0;
    for (int c = 0; c < 14; c++) begin
      if (nrn == 0)      set_req(1'b1, 1'b1, 32'h0, 3'd1);
      else if (nrn == 1) set_req(1'b1, 1'b1, 32'h100, 3'd2);
      else               bus.req_rqempty = 1'b1;
      #1;
      if (bus.app_en && bus.app_rdy) begin
        chk("t4_addr", 128'(bus.app_addr), 128'((nrn == 0 ? 0 : 32'h80) + 8 * kacc));
        nacc++;
        kacc++;
      end
      if (bus.req_rnext) begin
        nrn++;
        kacc = 0;
      end
      step();
    end
    bus.rdq_pop = 1'b0;
    chk("t4_nrnext", 128'(nrn), 128'd2);
    chk("t4_nacc", 128'(nacc), 128'd5);
    beat = 0;
    for (int c = 0; c < 10; c++) begin
      vld = (c == 0) || (c == 2) || (c == 3) || (c == 6) || (c == 8);
      bus.app_rd_data_valid = vld;
      bus.app_rd_data = 128'(32'h10 + beat);
      #1;
      if (vld) begin
        chk("t4_wen", 128'(bus.rdq_wen), 128'h1);
        chk("t4_last", 128'(bus.rdq_last), 128'((beat == 1) || (beat == 4)));
        chk("t4_wdata", bus.rdq_wdata, 128'(32'h10 + beat));
        beat++;
      end else begin
        chk("t4_wen_idle", 128'(bus.rdq_wen), 128'h0);
      end
      step();
    end
    bus.app_rd_data_valid = 1'b0;
    #1;
    chk("t4_rd_err", 128'(bus.rd_err), 128'h0);

    // Stray read return with nothing outstanding
    bus.app_rd_data_valid = 1'b1;
    bus.app_rd_data = 128'hBAD;
    #1;
    chk("t5_stray_wen", 128'(bus.rdq_wen), 128'h1);
    chk("t5_stray_last", 128'(bus.rdq_last), 128'h0);
    step();
    bus.app_rd_data_valid = 1'b0;
    #1;
    chk("t5_rd_err_set", 128'(bus.rd_err), 128'h1);
    step();
    step();
    step();
    chk("t5_rd_err_sticky", 128'(bus.rd_err), 128'h1);

    // Reset in the middle of a write burst (after 2 of 4 beats)
    set_req(1'b1, 1'b0, 32'h0, 3'd3);
    bus.app_rdy = 1'b1;
    bus.app_wdf_rdy = 1'b1;
    bus.wdq_rqempty = 1'b0;
    ncmd = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (bus.app_en && bus.app_rdy) ncmd++;
      step();
    end
    chk("t5_mid_ncmd", 128'(ncmd), 128'd2);
    mrst = 1'b1;
    #1;
    chk("t5_mid_en", 128'(bus.app_en), 128'h1);
    step();
    mrst = 1'b0;
    bus.req_rqempty = 1'b1;
    bus.wdq_rqempty = 1'b1;
    #1;
    chk("t5_rst_en", 128'(bus.app_en), 128'h0);
    chk("t5_rst_wren", 128'(bus.app_wdf_wren), 128'h0);
    chk("t5_rst_rnext", 128'(bus.req_rnext), 128'h0);
    chk("t5_rst_rd_err", 128'(bus.rd_err), 128'h0);

    // Length fifo full: third read waits for the first return beat
    nrn = 0;
    for (int c = 0; c < 12; c++) begin
      if (nrn < 3) set_req(1'b1, 1'b1, 32'(nrn) * 32'h100, 3'd0);
      else         bus.req_rqempty = 1'b1;
      #1;
      if (bus.req_rnext) nrn++;
      step();
    end
    chk("t6_two_issued", 128'(nrn), 128'd2);
    chk("t6_blocked_en", 128'(bus.app_en), 128'h0);
    bus.app_rd_data_valid = 1'b1;
    bus.app_rd_data = 128'h600D;
    #1;
    chk("t6_ret_last", 128'(bus.rdq_last), 128'h1);
    step();
    bus.app_rd_data_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.req_rqempty = (nrn >= 3);
      #1;
      if (bus.req_rnext) begin
        chk("t6_third_addr", 128'(bus.app_addr), 128'h100);
        nrn++;
      end
      step();
    end
    chk("t6_third_issued", 128'(nrn), 128'd3);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/mig_if_burst.md
Name: mig_if_burst

Overview:
Parametrised successor MIG user-interface bridge. It pops requests from the request queue and expands each into (len+1) single-beat MIG commands with auto-incrementing column address. For writes it streams the matching write-data beats from the wdq. Read returns are pushed into the rdq, with a per-request last-beat marker and credit-based rdq overflow protection.

Parameters:
DATA_W, 128, MIG app data width (bits); power of 2, ≥ 64
MASK_W, DATA_W/8, byte-mask width
ADDR_W, 28, app_addr width
LEN_W, 3, request length field width (len = beats-1, max 2^LEN_W beats)
RDQ_DEPTH, 16, rdq entries; initial read credit
MAX_RD_REQ, 4, outstanding read requests tracked (length fifo depth, power of 2)

Ports:
mclk  in  1  clock (single clock domain)
mrst  in  1  synchronous active-high reset
app_addr  out  ADDR_W  MIG command address
app_cmd  out  3  3'b000 write, 3'b001 read
app_en  out  1  command valid
app_rdy  in  1  MIG command ready
app_wdf_data  out  DATA_W  write data
app_wdf_mask  out  MASK_W  write byte mask (1 = masked)
app_wdf_wren  out  1  write data valid
app_wdf_end  out  1  last word of wdf burst (= app_wdf_wren, 4:1 mode)
app_wdf_rdy  in  1  MIG write-data ready
app_rd_data  in  DATA_W  read data
app_rd_data_valid  in  1  read data valid
req_rnext  out  1  pop request queue (1-cycle pulse)
req_rqempty  in  1  request queue empty
req_qraddr  in  32  byte address
req_rd_bwt  in  1  1 = read, 0 = write
req_len  in  LEN_W  beats-1
wdq_rnext  out  1  pop write-data queue
wdq_rqempty  in  1  wdq empty
wdq_mask_rdata  in  MASK_W+DATA_W  {mask, data}
rdq_wen  out  1  rdq push
rdq_wdata  out  DATA_W  rdq push data
rdq_last  out  1  push is last beat of its request
rdq_pop  in  1  consumer popped one rdq entry (returns one credit)
rd_err  out  1  sticky: read data with no outstanding request

Behaviour:
- Reset (mrst=1 at posedge): state IDLE, cmd_cnt/dat_cnt/rbeat_cnt=0, credit=RDQ_DEPTH, length fifo empty, rd_err=0. All control outputs are 0 while in IDLE.
- Base column address: colbase = ((req_qraddr >> log2(MASK_W)) << 3). app_addr = {1'b0, (colbase + 8*cmd_cnt)[ADDR_W-2:0]}. Wraps modulo 2^(ADDR_W-1); no carry into MSB.
- IDLE:
  - ~req_rqempty & req_rd_bwt & length fifo not full -> RD_ISSUE. On the transition, push req_len into the length fifo and clear cmd_cnt.
  - ~req_rqempty & ~req_rd_bwt -> WR_ISSUE. Clear cmd_cnt and dat_cnt.
  - Read with length fifo full -> stay in IDLE.
- RD_ISSUE:
  - app_en = (credit != 0); app_cmd = 001.
  - Accept = app_en & app_rdy: cmd_cnt+1, credit-1.
  - Accept with cmd_cnt == req_len: pulse req_rnext, go to IDLE.
- WR_ISSUE: command and data sides run independently.
  - app_en = (cmd_cnt ≤ req_len); app_cmd = 000. Accept -> cmd_cnt+1.
  - app_wdf_wren = (dat_cnt ≤ req_len) & ~wdq_rqempty. wdq_rnext = app_wdf_wren & app_wdf_rdy, which increments dat_cnt.
  - Exit when the last command and the last data beat have both been accepted, in the same or different cycles. req_rnext pulses in the cycle the later of the two is accepted; next state IDLE.
- Request fields (req_qraddr, req_rd_bwt, req_len) are held stable by the queue until req_rnext.
- Credit: −1 per read command accept, +1 per rdq_pop; both in one cycle leaves it unchanged. Credit never exceeds RDQ_DEPTH; rdq_pop at full credit is ignored.
- Read return:
  - rdq_wen = app_rd_data_valid; rdq_wdata = app_rd_data; zero latency, no register stage.
  - rdq_last = valid & (rbeat_cnt == fifo head).
  - On a valid beat, rbeat_cnt+1; on a last beat, clear rbeat_cnt and pop the length fifo.
  - Push and pop of the length fifo in the same cycle are both honoured.
  - Valid with the fifo empty: rd_err <= 1 (sticky until reset), data still forwarded, rdq_last=0.
- Reset mid-operation: all state is discarded immediately with no drain. Any partially issued burst is the system's responsibility.

Decomposition:
- Package mig_if_pkg: CMD_WR=3'b000, CMD_RD=3'b001, state enum {IDLE, RD_ISSUE, WR_ISSUE}, clog2 function.
- One sub-module, mig_len_fifo: MAX_RD_REQ × LEN_W synchronous FIFO with full/empty flags and simultaneous push/pop, same mclk/mrst.

Test Plan:
- Read, addr 0x0000_0120, len 0 → app_addr 0x090, cmd 001; one req_rnext; one return beat → rdq_wen=1, rdq_last=1.
- Write, len 3, addr 0x40, app_rdy low on alternate cycles, app_wdf_rdy held low 5 cycles → addrs 0x20, 0x28, 0x30, 0x38; exactly 4 wdq_rnext; req_rnext only after both sides complete.
- RDQ_DEPTH=4, read len 7, no rdq_pop → exactly 4 commands accepted, then app_en=0. Pulse rdq_pop twice → 2 more commands issue.
- Two back-to-back reads, len 1 then len 2, returns interleaved with gaps → rdq_last on beats 2 and 5 only; length fifo empty at end.
- app_rd_data_valid with nothing outstanding → rd_err=1, held until mrst. Then assert mrst mid-WR_ISSUE (after 2 of 4 beats) → next cycle state IDLE, outputs 0, credit=RDQ_DEPTH.
- MAX_RD_REQ=2: three single-beat reads with no return data → third read waits in IDLE until the first return beat pops the length fifo.
